// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: instruction
// patterns, CSR addresses, mcause codes, mstatus bit positions, hold
// levels and the FSM state type.
package trap_ctrl_pkg;

  // System instruction encodings matched in decode
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // Machine-mode CSR addresses written by the sequencer
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mcause values; bit 31 marks an asynchronous cause
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  // mstatus bit positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // Hold request levels toward the central controller
  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;

  // Sequencer states
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE        = 3'd0,
    WR_MEPC     = 3'd1,
    WR_MCAUSE   = 3'd2,
    WR_MSTATUS  = 3'd3,
    ASSERT      = 3'd4,
    MRET_WR     = 3'd5,
    MRET_ASSERT = 3'd6
  } state_t;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer. Detects ECALL/EBREAK/MRET and level
// external interrupts while idle, holds the pipeline, walks the CSR write
// sequence and finishes with a one-cycle redirect strobe to execute.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_busy_i,
  input  logic [DATA_W-1:0] csr_mtvec_i,
  input  logic [DATA_W-1:0] csr_mepc_i,
  input  logic [DATA_W-1:0] csr_mstatus_i,
  output logic              hold_flag_o,
  output logic              we_o,
  output logic [11:0]       waddr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              int_assert_o,
  output logic [ADDR_W-1:0] int_addr_o
);

  // Trap entry: MPIE <= MIE, MIE <= 0
  function automatic logic [DATA_W-1:0] trap_mstatus(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = s;
    r[MSTATUS_MPIE_BIT] = s[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1
  function automatic logic [DATA_W-1:0] mret_mstatus(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = s;
    r[MSTATUS_MIE_BIT]  = s[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    return r;
  endfunction

  state_t state, state_next;

  logic              is_ecall, is_ebreak, is_mret;
  logic              mie;
  logic              sync_trap, async_trap, trigger;
  logic [ADDR_W-1:0] mepc_q;
  logic [DATA_W-1:0] cause_q;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign mie       = csr_mstatus_i[MSTATUS_MIE_BIT];

  // Synchronous exceptions outrank interrupts, which outrank MRET. An
  // interrupt seen while execute is busy simply waits; the line is level.
  assign sync_trap  = is_ecall | is_ebreak;
  assign async_trap = (|int_flag_i) & mie & ~ex_busy_i;
  // Reset gates the trigger so the combinational hold stays low under reset.
  assign trigger    = ~rst & (state == IDLE) & (sync_trap | async_trap | is_mret);

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture return address and cause at the trigger cycle (data only, no reset)
  always_ff @(posedge clk) begin
    if (state == IDLE && (sync_trap || async_trap)) begin
      if (sync_trap) begin
        mepc_q  <= inst_addr_i;
        cause_q <= is_ecall ? DATA_W'(CAUSE_ECALL) : DATA_W'(CAUSE_EBREAK);
      end else begin
        // An interrupt lands on the instruction execute is about to run next
        mepc_q  <= jump_flag_i ? jump_addr_i : inst_addr_i;
        cause_q <= DATA_W'(CAUSE_EXT_INT);
      end
    end
  end

  // Next-state and output decode; everything idles at zero by default
  always_comb begin
    state_next   = state;
    hold_flag_o  = HOLD_DISABLE;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state)
      IDLE: begin
        if (trigger) begin
          hold_flag_o = HOLD_ENABLE;
          state_next  = (sync_trap || async_trap) ? WR_MEPC : MRET_WR;
        end
      end
      WR_MEPC: begin
        hold_flag_o = HOLD_ENABLE;
        we_o        = 1'b1;
        waddr_o     = CSR_MEPC;
        data_o      = DATA_W'(mepc_q);
        state_next  = WR_MCAUSE;
      end
      WR_MCAUSE: begin
        hold_flag_o = HOLD_ENABLE;
        we_o        = 1'b1;
        waddr_o     = CSR_MCAUSE;
        data_o      = cause_q;
        state_next  = WR_MSTATUS;
      end
      WR_MSTATUS: begin
        // mstatus is taken live in this cycle, not from the trigger cycle
        hold_flag_o = HOLD_ENABLE;
        we_o        = 1'b1;
        waddr_o     = CSR_MSTATUS;
        data_o      = trap_mstatus(csr_mstatus_i);
        state_next  = ASSERT;
      end
      ASSERT: begin
        hold_flag_o  = HOLD_ENABLE;
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(csr_mtvec_i);
        state_next   = IDLE;
      end
      MRET_WR: begin
        hold_flag_o = HOLD_ENABLE;
        we_o        = 1'b1;
        waddr_o     = CSR_MSTATUS;
        data_o      = mret_mstatus(csr_mstatus_i);
        state_next  = MRET_ASSERT;
      end
      MRET_ASSERT: begin
        hold_flag_o  = HOLD_ENABLE;
        int_assert_o = 1'b1;
        int_addr_o   = ADDR_W'(csr_mepc_i);
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
